lifo_stack_ctrl: RTL and testbench
==================================

// Module: lifo_stack_ctrl
// PURPOSE
//   Parametrised LIFO stack with registered pop data, combinational top-of-stack peek,
//   and occupancy count with almost-full/almost-empty thresholds. Handles simultaneous
//   push+pop as a replace-top, and provides a synchronous clear. Over/underflow flags are
//   sticky. Drop-in stack buffer for datapaths needing LIFO ordering with status.
// PARAMETERS
//   WIDTH      8  data word width in bits (>=1)
//   DEPTH      8  number of stack entries (>=2)
//   AF_MARGIN  1  almost_full asserted when count >= DEPTH-AF_MARGIN (0 < AF_MARGIN < DEPTH)
//   AE_MARGIN  1  almost_empty asserted when count <= AE_MARGIN (0 < AE_MARGIN < DEPTH)
//   CW (local) $clog2(DEPTH+1), width of count
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   rstn          in   1      reset, synchronous, active-low
//   clear         in   1      synchronous flush: empties stack and clears error flags
//   push          in   1      push request, din written on this edge
//   pop           in   1      pop request
//   din           in   WIDTH  push data
//   dout          out  WIDTH  popped word, registered, valid when dout_valid=1
//   dout_valid    out  1      one-cycle pulse: dout updated by an accepted pop/replace
//   top           out  WIDTH  combinational peek of top entry; 0 when empty
//   count         out  CW     current occupancy, 0..DEPTH
//   empty         out  1      count==0
//   full          out  1      count==DEPTH
//   almost_full   out  1      count >= DEPTH-AF_MARGIN
//   almost_empty  out  1      count <= AE_MARGIN
//   overflow      out  1      sticky: push rejected because full (no pop in same cycle)
//   underflow     out  1      sticky: pop rejected because empty
// BEHAVIOUR
//   - Reset (rstn=0 at edge): count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
//     Memory array is not reset. rstn has priority over everything.
//   - Priority below reset: clear > push/pop. clear: count=0, overflow=underflow=0,
//     dout_valid=0, dout holds; push/pop in that cycle are ignored.
//   - Status outputs (empty/full/almost_*, top) derive combinationally from count/memory.
//   - Per edge, from pre-edge count N (no reset, no clear):
//     push only, N<DEPTH : mem[N]<=din, count<=N+1.
//     push only, N==DEPTH: ignored, overflow<=1.
//     pop only,  N>0     : dout<=mem[N-1], dout_valid<=1, count<=N-1.
//     pop only,  N==0    : ignored, underflow<=1, dout holds, dout_valid<=0.
//     push+pop,  N>0     : replace-top: dout<=mem[N-1], dout_valid<=1, mem[N-1]<=din,
//                          count unchanged (legal also when full; no overflow).
//     push+pop,  N==0    : push accepted (mem[0]<=din, count<=1), pop rejected,
//                          underflow<=1, dout_valid<=0.
//     neither            : state holds, dout_valid<=0.
//   - Pop latency: dout/dout_valid visible one cycle after the requesting edge.
//   - Address arithmetic in CW bits; count never wraps (saturates via rejection rules).
//   - Sticky flags clear only on rstn or clear.
// TESTING
//   1. Reset, push 0x11..0x18 (8 pushes) -> count=8, full=1, almost_full from count=7,
//      top=0x18; 9th push 0x99 -> overflow=1, count=8, top=0x18.
//   2. From full, pop x8 -> dout 0x18,0x17..0x11 each with dout_valid=1 one cycle later;
//      empty=1, almost_empty at count<=1; 9th pop -> underflow=1, dout_valid=0, dout=0x11.
//   3. count=3 (top 0x13), push+pop din=0xAA -> next cycle dout=0x13, dout_valid=1,
//      top=0xAA, count=3; repeat when full -> no overflow, count=8.
//   4. Empty, push+pop din=0x55 -> count=1, top=0x55, underflow=1, dout_valid=0.
//   5. count=5, overflow=1, assert clear with push=1 -> count=0, empty=1, overflow=0,
//      top=0; following push 0x22 -> count=1, top=0x22.
//   6. rstn=0 mid-stream (count=4, dout_valid=1) -> after edge all outputs at reset values.

Source files
------------

// File: rtl/lifo_stack_if.sv
// ---------------------------------------------------------------------------
// lifo_stack_if
//   Bundles the request and status signals of lifo_stack_ctrl.
//   master : the client. It drives clear/push/pop/din and observes the status.
//   slave  : the stack controller itself.
//   Signals
//     clear, push, pop, din        request side (master -> slave)
//     dout, dout_valid             registered pop result
//     top                          combinational peek of the top entry
//     count, empty, full,
//     almost_full, almost_empty    occupancy status
//     overflow, underflow          sticky error flags
// ---------------------------------------------------------------------------
interface lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, din,
        input  dout, dout_valid, top, count, empty, full,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, din,
        output dout, dout_valid, top, count, empty, full,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// ---------------------------------------------------------------------------
// lifo_stack_ctrl
//   Parametrised LIFO stack. Pop data is registered (one cycle latency, flagged
//   by a one-cycle dout_valid pulse); the top entry is also visible
//   combinationally. Simultaneous push+pop replaces the top entry in place.
//   clear flushes the stack and the sticky overflow/underflow flags.
//   Ports
//     clk   : clock, rising edge
//     rstn  : synchronous active-low reset, highest priority
//     bus   : lifo_stack_if.slave (requests in, data/status out)
// ---------------------------------------------------------------------------
module lifo_stack_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic         clk,
    input  logic         rstn,
    lifo_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_MARGIN);

    // Storage: no reset, only count decides which entries are live.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_word;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);
    // Only meaningful when not empty; truncation to AW bits is exact for
    // count values 1..DEPTH.
    assign top_addr = AW'(count_q - CW'(1));
    assign top_word = mem[top_addr];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        mem_we       = 1'b0;
        mem_waddr    = top_addr;
        mem_wdata    = bus.din;

        if (bus.clear) begin
            // Flush: requests in the same cycle are dropped, dout holds.
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            unique case ({bus.push, bus.pop})
                2'b10: begin
                    if (!is_full) begin
                        mem_we    = 1'b1;
                        mem_waddr = AW'(count_q);
                        count_d   = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        dout_d       = top_word;
                        dout_valid_d = 1'b1;
                        count_d      = count_q - CW'(1);
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (!is_empty) begin
                        // Replace-top: old top goes out, din takes its slot.
                        // Legal when full since occupancy does not change.
                        dout_d       = top_word;
                        dout_valid_d = 1'b1;
                        mem_we       = 1'b1;
                        mem_waddr    = top_addr;
                    end else begin
                        // Nothing to pop; the push half still lands.
                        mem_we      = 1'b1;
                        mem_waddr   = '0;
                        count_d     = CW'(1);
                        underflow_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Memory write port; blocked during reset so reset truly dominates.
    always_ff @(posedge clk) begin
        if (rstn && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.top          = is_empty ? '0 : top_word;
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack_ctrl
//   Drives directed and random request sequences into lifo_stack_ctrl. A
//   queue-based stack model predicts, per clock edge, the status snapshot and
//   any popped word; both are queued and consumed by an independent monitor.
// ---------------------------------------------------------------------------
module tb_lifo_stack_ctrl;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 1;
    localparam int AE_MARGIN = 1;
    localparam int CW        = $clog2(DEPTH + 1);

    logic clk;
    logic rstn;

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

    lifo_stack_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] top;
        logic             empty;
        logic             full;
        logic             af;
        logic             ae;
        logic             ovf;
        logic             udf;
        logic [WIDTH-1:0] dout;
        logic             valid;
    } snap_t;

    snap_t            snap_q[$];
    logic [WIDTH-1:0] data_q[$];

    // Reference model state
    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid, m_ovf, m_udf;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL edge %0d %s: got 0x%0h expected 0x%0h", edge_no, name, act, exp);
        end
    endtask

    // Apply one cycle of requests at the falling edge and advance the model.
    task automatic step(input logic r, input logic clr, input logic ps,
                        input logic pp, input logic [WIDTH-1:0] d);
        snap_t s;
        @(negedge clk);
        rstn         = r;
        bus_if.clear = clr;
        bus_if.push  = ps;
        bus_if.pop   = pp;
        bus_if.din   = d;

        m_valid = 1'b0;
        if (!r) begin
            stk.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else if (clr) begin
            stk.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (ps && pp) begin
            if (stk.size() > 0) begin
                m_dout  = stk.pop_back();
                m_valid = 1'b1;
                data_q.push_back(m_dout);
            end else begin
                m_udf = 1'b1;
            end
            stk.push_back(d);
        end else if (ps) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else                    m_ovf = 1'b1;
        end else if (pp) begin
            if (stk.size() > 0) begin
                m_dout  = stk.pop_back();
                m_valid = 1'b1;
                data_q.push_back(m_dout);
            end else begin
                m_udf = 1'b1;
            end
        end

        s.count = CW'(stk.size());
        s.top   = (stk.size() > 0) ? stk[$] : '0;
        s.empty = (stk.size() == 0);
        s.full  = (stk.size() == DEPTH);
        s.af    = (stk.size() >= DEPTH - AF_MARGIN);
        s.ae    = (stk.size() <= AE_MARGIN);
        s.ovf   = m_ovf;
        s.udf   = m_udf;
        s.dout  = m_dout;
        s.valid = m_valid;
        snap_q.push_back(s);
    endtask

    // Monitor: after each rising edge compare against the queued prediction.
    initial begin
        snap_t e;
        logic [WIDTH-1:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (snap_q.size() > 0) begin
                e = snap_q.pop_front();
                edge_no++;
                chk("count",        32'(bus_if.count),        32'(e.count));
                chk("top",          32'(bus_if.top),          32'(e.top));
                chk("empty",        32'(bus_if.empty),        32'(e.empty));
                chk("full",         32'(bus_if.full),         32'(e.full));
                chk("almost_full",  32'(bus_if.almost_full),  32'(e.af));
                chk("almost_empty", 32'(bus_if.almost_empty), 32'(e.ae));
                chk("overflow",     32'(bus_if.overflow),     32'(e.ovf));
                chk("underflow",    32'(bus_if.underflow),    32'(e.udf));
                chk("dout_valid",   32'(bus_if.dout_valid),   32'(e.valid));
                chk("dout",         32'(bus_if.dout),         32'(e.dout));
                if (bus_if.dout_valid === 1'b1) begin
                    if (data_q.size() == 0) begin
                        chk("pop_data_unexpected", 32'(bus_if.dout_valid), 32'd0);
                    end else begin
                        w = data_q.pop_front();
                        chk("pop_data", 32'(bus_if.dout), 32'(w));
                        $display("pop edge %0d: dout=0x%0h expected 0x%0h", edge_no, bus_if.dout, w);
                    end
                end
            end
        end
    end

    initial begin
        rstn         = 1'b0;
        bus_if.clear = 1'b0;
        bus_if.push  = 1'b0;
        bus_if.pop   = 1'b0;
        bus_if.din   = '0;
        m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // 1. reset, fill, overflow
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
        // 2. drain, underflow
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // 3. replace-top at count 3, then at full
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h31 + i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hBB);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // 4. push+pop on empty
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
        // 5. overflow at full, back to 5, clear with push
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h41 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        // 6. reset mid-stream right after a pop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h23 + i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h66);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Random phases alternating push-heavy and pop-heavy traffic.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 400; i++) begin
                logic r, c, ps, pp;
                r  = ($urandom_range(0, 199) != 0);
                c  = ($urandom_range(0, 59) == 0);
                ps = (ph % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
                pp = (ph % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
                step(r, c, ps, pp, 8'($urandom));
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        chk("pending_snapshots", 32'(snap_q.size()), 32'd0);
        chk("pending_pop_data",  32'(data_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
